apb_master_arbiter: RTL and testbench

//  Round-robin arbiter + APB master sequencer sharing one APB slave (apb_mem) among NREQ requesters.

---
 rtl/apb_master_arbiter_if.sv | 33 +++
 rtl/apb_master_arbiter.sv | 170 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_if.sv
// Requester command/response and APB master bus bundle for apb_master_arbiter.
interface apb_master_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_write;
  logic [NREQ-1:0][31:0] req_addr;
  logic [NREQ-1:0][31:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  _PSEL1;
  logic                  _PENABLE;
  logic                  _PWRITE;
  logic [31:0]           _PADDR;
  logic [31:0]           _PWDATA;
  logic [31:0]           _PRDATA;
  logic                  _PREADY;
  logic                  _PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, _PRDATA, _PREADY, _PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           _PSEL1, _PENABLE, _PWRITE, _PADDR, _PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, _PRDATA, _PREADY, _PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           _PSEL1, _PENABLE, _PWRITE, _PADDR, _PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter feeding a single APB master sequencer (IDLE/SETUP/ACCESS).
// Optional ACCESS watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int NREQ = 4
`ifdef APB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                _PCLK,
  input  logic                _PRESETn,
  apb_master_arbiter_if.master bus_io
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef APB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic              psel_q, psel_d;
  logic              pen_q, pen_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [NREQ-1:0]   rdy_q, rdy_d;
  logic [NREQ-1:0]   rspv_q, rspv_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
`ifdef APB_TIMEOUT_EN
  logic [TW-1:0]     cnt_q, cnt_d;
`endif

  // Search starts just past the last winner so it drops to lowest priority.
  logic          arb_found;
  logic [PW-1:0] arb_idx;
  logic [PW-1:0] cand;
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!arb_found && bus_io.req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdy_d    = '0;
    rspv_d   = '0;
    rdata_d  = '0;
    err_d    = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        psel_d = 1'b0;
        pen_d  = 1'b0;
        if (arb_found) begin
          rdy_d[arb_idx] = 1'b1;
          ptr_d    = arb_idx;
          gnt_d    = arb_idx;
          pwrite_d = bus_io.req_write[arb_idx];
          paddr_d  = bus_io.req_addr[arb_idx];
          pwdata_d = bus_io.req_wdata[arb_idx];
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        pen_d   = 1'b1;
        state_d = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_ACCESS: begin
        if (bus_io._PREADY) begin
          rspv_d[gnt_q] = 1'b1;
          err_d   = bus_io._PSLVERR;
          rdata_d = (!pwrite_q && !bus_io._PSLVERR) ? bus_io._PRDATA : '0;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          state_d = S_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        // Abort on the cycle the stall count would reach the limit.
        else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rspv_d[gnt_q] = 1'b1;
          err_d   = 1'b1;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        psel_d  = 1'b0;
        pen_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge _PCLK or negedge _PRESETn) begin
    if (!_PRESETn) begin
      state_q  <= S_IDLE;
      ptr_q    <= PW'(NREQ - 1);
      gnt_q    <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdy_q    <= '0;
      rspv_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdy_q    <= rdy_d;
      rspv_q   <= rspv_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus_io.req_ready = rdy_q;
  assign bus_io.rsp_valid = rspv_q;
  assign bus_io.rsp_rdata = rdata_q;
  assign bus_io.rsp_err   = err_q;
  assign bus_io._PSEL1    = psel_q;
  assign bus_io._PENABLE  = pen_q;
  assign bus_io._PWRITE   = pwrite_q;
  assign bus_io._PADDR    = paddr_q;
  assign bus_io._PWDATA   = pwdata_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: transaction-level round-robin/APB timing model,
// behavioural APB slave memory, directed steps plus randomized traffic.
module tb_apb_master_arbiter;
  localparam int N = 4;
`ifdef APB_TIMEOUT_EN
  localparam int TO = 64;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
  } txn_t;

  logic pclk  = 1'b0;
  logic prstn = 1'b0;
  always #5 pclk = ~pclk;

  apb_master_arbiter_if #(.NREQ(N)) bus();

  apb_master_arbiter #(
    .NREQ(N)
`ifdef APB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    ._PCLK   (pclk),
    ._PRESETn(prstn),
    .bus_io  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Requester side: pending commands and which ones are currently asserted.
  txn_t           q [N][$];
  logic [N-1:0]   av = '0;
  bit             force_all = 1'b1;

  // Reference model: one transfer in flight, grant/response cycles by arithmetic.
  bit             busy = 1'b0;
  int             ptr = N - 1;
  int             cur_g = 0;
  int             grant_cyc = -1;
  int             rsp_cyc = -1;
  txn_t           cur;
  bit             cur_to = 1'b0;
  logic           exp_err = 1'b0;
  logic [31:0]    exp_rdata = '0;
  logic [31:0]    mem [logic [31:0]];

  int             glog[$];
  int             rdy_obs = 0;
  int             rsp_obs = 0;
  logic [31:0]    last_rdata = '0;
  logic           last_err = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5EED_0000;
  endfunction

  function automatic int rr(input int p, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic add(input int r, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input int w, input logic e);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = d; t.waits = w; t.err = e;
    q[r].push_back(t);
  endtask

  task automatic check_outputs();
    logic [N-1:0] er;
    logic [N-1:0] ev;
    bit sel;
    bit en;
    er = '0;
    ev = '0;
    if (!prstn) begin
      chk("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata,
          bus._PSEL1, bus._PENABLE, bus._PWRITE, bus._PADDR, bus._PWDATA}, '0);
    end else begin
      if (cyc == grant_cyc) er[cur_g] = 1'b1;
      if (busy && cyc == rsp_cyc) ev[cur_g] = 1'b1;
      sel = busy && cyc >= grant_cyc && cyc < rsp_cyc;
      en  = busy && cyc >  grant_cyc && cyc < rsp_cyc;
      chk("req_ready", bus.req_ready, er);
      chk("rsp_valid", bus.rsp_valid, ev);
      chk("psel_penable", {bus._PSEL1, bus._PENABLE}, {sel, en});
      if (sel) chk("bus_cmd", {bus._PWRITE, bus._PADDR, bus._PWDATA},
                   {cur.wr, cur.addr, cur.wdata});
      if (ev != '0) chk("rsp_data", {bus.rsp_err, bus.rsp_rdata}, {exp_err, exp_rdata});
    end
  endtask

  // One clock: check at the falling edge, then update model and drive inputs.
  task automatic tick(input logic rv);
    bit acc;
    @(negedge pclk);
    cyc++;
    check_outputs();
    if (bus.req_ready != '0) begin
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) glog.push_back(i);
      rdy_obs = cyc;
    end
    if (bus.rsp_valid != '0) begin
      rsp_obs    = cyc;
      last_rdata = bus.rsp_rdata;
      last_err   = bus.rsp_err;
    end
    if (cyc == grant_cyc) av[cur_g] = 1'b0;
    if (busy && cyc == rsp_cyc) busy = 1'b0;
    prstn = rv;
    if (!rv) begin
      busy = 1'b0; ptr = N - 1; grant_cyc = -1; rsp_cyc = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (!av[i] && q[i].size() > 0 && (force_all || $urandom_range(1, 0) == 1)) av[i] = 1'b1;
      if (av[i]) begin
        bus.req_write[i] = q[i][0].wr;
        bus.req_addr[i]  = q[i][0].addr;
        bus.req_wdata[i] = q[i][0].wdata;
      end else begin
        bus.req_write[i] = 1'($urandom);
        bus.req_addr[i]  = $urandom;
        bus.req_wdata[i] = $urandom;
      end
    end
    bus.req_valid = av;
    acc = busy && cyc > grant_cyc && cyc < rsp_cyc;
    if (acc) begin
      bus._PREADY  = !cur_to && (cyc == rsp_cyc - 1);
      bus._PSLVERR = bus._PREADY ? cur.err : 1'($urandom);
      bus._PRDATA  = (bus._PREADY && !cur.wr && !cur.err) ? exp_rdata : $urandom;
    end else begin
      bus._PREADY  = 1'($urandom);
      bus._PSLVERR = 1'($urandom);
      bus._PRDATA  = $urandom;
    end
    if (prstn && !busy && av != '0) begin
      cur_g     = rr(ptr, av);
      ptr       = cur_g;
      cur       = q[cur_g].pop_front();
      grant_cyc = cyc + 1;
      busy      = 1'b1;
      cur_to    = 1'b0;
`ifdef APB_TIMEOUT_EN
      if (cur.waits >= TO) begin
        cur_to    = 1'b1;
        rsp_cyc   = cyc + 2 + TO;
        exp_err   = 1'b1;
        exp_rdata = '0;
      end else
`endif
      begin
        // SETUP, then waits+1 ACCESS cycles, then the registered response.
        rsp_cyc   = cyc + 3 + cur.waits;
        exp_err   = cur.err;
        exp_rdata = (!cur.wr && !cur.err) ? rd(cur.addr) : '0;
        if (cur.wr && !cur.err) mem[cur.addr] = cur.wdata;
      end
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
    return av != '0;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || pending()) && n < budget) begin
      tick(1'b1);
      n++;
    end
    chk(tag, 128'(n < budget), 128'd1);
  endtask

  initial begin
    int ord [5];
    int n;
    ord = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus._PREADY   = 1'b0;
    bus._PSLVERR  = 1'b0;
    bus._PRDATA   = '0;

    // All four requesting through reset, then rotation with zero wait states.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        add(i, 1'($urandom), 32'h80 + 32'(4 * $urandom_range(7, 0)), $urandom, 0, 1'b0);
    repeat (4) tick(1'b0);
    glog.delete();
    drain("drain_rotate", 200);
    chk("grant_count", glog.size(), 8);
    for (int k = 0; k < 5; k++) chk("grant_order", glog[k], ord[k]);

    // Single write then read-back on requester 0.
    add(0, 1'b1, 32'h40, 32'hA5A5_0001, 0, 1'b0);
    drain("drain_wr", 50);
    chk("wr_latency", rsp_obs - rdy_obs, 2);
    chk("wr_err", last_err, 1'b0);
    add(0, 1'b0, 32'h40, $urandom, 0, 1'b0);
    drain("drain_rd", 50);
    chk("rd_latency", rsp_obs - rdy_obs, 2);
    chk("rd_data", last_rdata, 32'hA5A5_0001);

    // Five wait states ending in a slave error.
    add(2, 1'b0, 32'h40, $urandom, 5, 1'b1);
    drain("drain_err", 50);
    chk("err_flag", last_err, 1'b1);
    chk("err_rdata", last_rdata, 32'h0);
    chk("wait_latency", rsp_obs - rdy_obs, 7);

    // Reset while in ACCESS; waiting requesters restart from requester 0.
    add(1, 1'b0, 32'h48, $urandom, 20, 1'b0);
    n = 0;
    while (!(busy && cyc > grant_cyc) && n < 50) begin
      tick(1'b1);
      n++;
    end
    chk("reach_access", 128'(n < 50), 128'd1);
    add(3, 1'b1, 32'h4C, $urandom, 0, 1'b0);
    add(0, 1'b1, 32'h50, $urandom, 1, 1'b0);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    glog.delete();
    tick(1'b1);
    drain("drain_post_rst", 100);
    chk("post_rst_first", glog[0], 0);
    chk("post_rst_second", glog[1], 3);

    // Randomized traffic with random assertion timing.
    force_all = 1'b0;
    for (int t = 0; t < 40; t++)
      add($urandom_range(N - 1, 0), 1'($urandom), 32'h40 + 32'(4 * $urandom_range(7, 0)),
          $urandom, $urandom_range(3, 0), $urandom_range(7, 0) == 0);
    drain("drain_random", 3000);
    force_all = 1'b1;

`ifdef APB_TIMEOUT_EN
    add(1, 1'b1, 32'h60, 32'hDEAD_BEEF, TO, 1'b0);
    drain("drain_timeout", 300);
    chk("to_err", last_err, 1'b1);
    chk("to_latency", rsp_obs - rdy_obs, TO + 1);
    add(1, 1'b0, 32'h60, $urandom, TO - 1, 1'b0);
    drain("drain_to_edge", 300);
    chk("to_edge_err", last_err, 1'b0);
    chk("to_edge_rdata", last_rdata, 32'h0000_0060 ^ 32'h5EED_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
